// File: rtl/counter_arbiter.sv
// =============================================================================
// Module   : counter_arbiter
// Brief    : Round-robin arbiter sharing one up-counter among N requesters.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module counter_arbiter #(
    parameter int N  = 4,
    parameter int CW = 8,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] len,
    input  logic            hold,
    output logic [N-1:0]    gnt,
    output logic [CW-1:0]   cnt,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   done_id
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Last winner starts at N-1 so requester 0 is searched first.
    localparam logic [IW-1:0] c_LAST_RST = IW'(N - 1);

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [IW-1:0]   done_id_q, done_id_d;
    logic [CW-1:0]   len_l_q, len_l_d;
    logic [IW-1:0]   last_q, last_d;

    logic            w_found;
    logic [IW-1:0]   w_pick;
    logic [IW:0]     w_cand;
    logic [N-1:0]    w_pick_oh;
    logic [CW-1:0]   w_pick_len;

    // Search last+1, last+2, ... modulo N; the sum is below 2N so one wrap suffices.
    always_comb begin
        w_found = 1'b0;
        w_pick  = last_q;
        w_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            w_cand = {1'b0, last_q} + (IW + 1)'(k);
            if (w_cand >= (IW + 1)'(N)) begin
                w_cand = w_cand - (IW + 1)'(N);
            end
            if (!w_found && req[w_cand[IW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IW-1:0];
            end
        end
    end

    always_comb begin
        w_pick_oh  = '0;
        w_pick_len = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick == IW'(i)) begin
                w_pick_oh[i] = 1'b1;
                w_pick_len   = len[i*CW +: CW];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        len_l_d   = len_l_q;
        last_d    = last_q;
        case (state_q)
            S_IDLE: begin
                if (w_found) begin
                    state_d = S_RUN;
                    gnt_d   = w_pick_oh;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    len_l_d = w_pick_len;
                    last_d  = w_pick;
                end
            end
            S_RUN: begin
                if (hold) begin
                    state_d = S_RUN;
                end else if (cnt_q != len_l_q) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    // Final count stays visible through DONE and IDLE.
                    state_d   = S_DONE;
                    gnt_d     = '0;
                    done_d    = 1'b1;
                    done_id_d = last_q;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            len_l_q   <= '0;
            last_q    <= c_LAST_RST;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            len_l_q   <= len_l_d;
            last_q    <= last_d;
        end
    end

    assign gnt     = gnt_q;
    assign cnt     = cnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_arbiter.sv
// =============================================================================
// Module   : tb_counter_arbiter
// Brief    : Scoreboard bench for counter_arbiter with directed vectors.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_counter_arbiter;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int IW = 2;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [N*CW-1:0] len;
    logic            hold;
    logic [N-1:0]    gnt;
    logic [CW-1:0]   cnt;
    logic            busy;
    logic            done;
    logic [IW-1:0]   done_id;

    counter_arbiter #(.N(N), .CW(CW), .IW(IW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .len     (len),
        .hold    (hold),
        .gnt     (gnt),
        .cnt     (cnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    typedef struct {
        logic [IW-1:0] id;
        logic [CW-1:0] fcnt;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input int id, input int fcnt, input int at);
        exp_t e;
        e.id   = IW'(id);
        e.fcnt = CW'(fcnt);
        e.cyc  = at;
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("done_cnt", 32'(cnt), 32'(e.fcnt));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_gnt", 32'(gnt), 32'd0);
                    chk("done_busy", 32'(busy), 32'd1);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c;
        rst_n = 1'b0;
        req   = '0;
        len   = '0;
        hold  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_done_id", 32'(done_id), 32'd0);
        rst_n = 1'b1;

        // Single request: requester 2, length 3.
        @(negedge clk);
        c = cyc;
        len[2*CW +: CW] = 8'd3;
        req = 4'b0100;
        push(2, 3, c + 5);
        for (int i = 0; i < 4; i++) begin
            wait_cyc(c + 1 + i);
            chk("single_gnt", 32'(gnt), 32'h4);
            chk("single_cnt", 32'(cnt), 32'(i));
            chk("single_busy", 32'(busy), 32'd1);
            req = 4'b0000;
        end
        wait_cyc(c + 6);
        chk("single_busy_low", 32'(busy), 32'd0);
        chk("single_cnt_kept", 32'(cnt), 32'd3);

        // Aborted transaction: requester 1 wins after last=2, reset at cnt=3.
        @(negedge clk);
        c = cyc;
        len[1*CW +: CW] = 8'd10;
        req = 4'b0010;
        wait_cyc(c + 1);
        chk("abort_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        wait_cyc(c + 4);
        chk("abort_cnt3", 32'(cnt), 32'd3);
        rst_n = 1'b0;
        #1;
        chk("abort_gnt0", 32'(gnt), 32'd0);
        chk("abort_cnt0", 32'(cnt), 32'd0);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_done0", 32'(done), 32'd0);

        // Round-robin after reset: 0,1,2,3,0 each length 1.
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        len = {8'd1, 8'd1, 8'd1, 8'd1};
        req = 4'b1111;
        for (int j = 0; j < 5; j++) push(j % N, 1, c + 3 + 4 * j);
        for (int j = 0; j < 5; j++) begin
            wait_cyc(c + 1 + 4 * j);
            chk("rr_gnt", 32'(gnt), 32'(1 << (j % N)));
            chk("rr_cnt0", 32'(cnt), 32'd0);
        end
        req = 4'b0000;
        wait_cyc(c + 20);

        // Hold: requester 1, length 5, frozen three cycles at cnt=2.
        @(negedge clk);
        c = cyc;
        len[1*CW +: CW] = 8'd5;
        req = 4'b0010;
        push(1, 5, c + 10);
        wait_cyc(c + 1);
        chk("hold_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        wait_cyc(c + 3);
        chk("hold_cnt_pre", 32'(cnt), 32'd2);
        hold = 1'b1;
        for (int i = 4; i <= 6; i++) begin
            wait_cyc(c + i);
            chk("hold_cnt_frozen", 32'(cnt), 32'd2);
        end
        hold = 1'b0;
        wait_cyc(c + 9);
        chk("hold_cnt_last", 32'(cnt), 32'd5);
        wait_cyc(c + 12);

        // Zero length: one RUN cycle then done.
        @(negedge clk);
        c = cyc;
        len[2*CW +: CW] = 8'd0;
        req = 4'b0100;
        push(2, 0, c + 2);
        wait_cyc(c + 1);
        chk("len0_gnt", 32'(gnt), 32'h4);
        chk("len0_cnt", 32'(cnt), 32'd0);
        req = 4'b0000;
        wait_cyc(c + 4);

        // Maximum length: counts to 255 without wrapping.
        @(negedge clk);
        c = cyc;
        len[3*CW +: CW] = 8'hFF;
        req = 4'b1000;
        push(3, 255, c + 257);
        wait_cyc(c + 1);
        chk("max_gnt", 32'(gnt), 32'h8);
        req = 4'b0000;
        wait_cyc(c + 256);
        chk("max_cnt_255", 32'(cnt), 32'd255);
        chk("max_gnt_held", 32'(gnt), 32'h8);
        wait_cyc(c + 258);
        chk("max_no_wrap", 32'(cnt), 32'd255);
        wait_cyc(c + 260);

        // Mid-run changes: drop req[0] and alter len[0]; original length wins.
        @(negedge clk);
        c = cyc;
        len[0*CW +: CW] = 8'd4;
        req = 4'b0001;
        push(0, 4, c + 6);
        wait_cyc(c + 1);
        chk("mid_gnt", 32'(gnt), 32'h1);
        wait_cyc(c + 2);
        req = 4'b0000;
        len[0*CW +: CW] = 8'h20;
        wait_cyc(c + 7);
        chk("mid_single_pulse", 32'(done), 32'd0);
        wait_cyc(c + 12);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin arbiter and sequencer that shares one up-counter datapath among N requesters in the counter design. Each requester raises a request with a target length; the block grants one requester at a time, runs the shared counter from 0 up to that length, then signals completion and re-arbitrates. It sits between the requesting units and the shared counter/logic datapath, owning all grant and count sequencing.

## Interface
- N, 4: number of requesters (2..8).
- CW, 8: counter / length width in bits.
- IW, 2: done_id width, must equal ceil(log2(N)).
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req  input  N  request per requester, level.
- len  input  N*CW  target length per requester; requester i uses bits [i*CW +: CW].
- hold  input  1  pause: freezes counter in RUN.
- gnt  output  N  one-hot grant, all-zero when no grant.
- cnt  output  CW  shared counter value.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.
- done_id  output  IW  index of completing requester, valid when done=1.

## Operation
- FSM states: IDLE, RUN, DONE; all outputs registered.
- Reset (async, rst_n=0): state=IDLE, gnt=0, cnt=0, busy=0, done=0, done_id=0, len_l=0, last=N-1 (requester 0 has top priority first).
- IDLE: if req!=0, pick first set req[i] searching i = last+1, last+2, ... modulo N; latch len_l=len[i], gnt=one-hot(i), cnt=0, last=i, go RUN. If req=0, stay IDLE, outputs unchanged except done=0.
- RUN: if hold=1, cnt holds, stay RUN. Else if cnt!=len_l, cnt=cnt+1. Else (cnt==len_l): go DONE, gnt=0, done=1, done_id=last; cnt keeps final value.
- DONE: done=0, go IDLE; cnt keeps final value until next grant.
- len sampled only at grant; later changes to len[i] ignored for the running transaction.
- req withdrawal during RUN/DONE ignored; transaction always completes.
- Requester still asserting req in IDLE after its done is a new request; competes under round-robin (will not win over another pending requester).
- len=0: one RUN cycle with cnt=0, then DONE.
- len=2^CW-1: counter reaches max, no wrap; cnt never exceeds len_l.
- hold in IDLE/DONE: no effect.
- Reset mid-transaction: immediate return to reset values; no done pulse emitted.

## Timing
- Request seen in IDLE at edge k -> gnt and busy high, cnt=0 after edge k (visible cycle k+1).
- Without hold, gnt high for len_l+1 cycles; cnt shows 0..len_l, one value per cycle.
- done high for exactly one cycle, same cycle gnt falls; busy stays high that cycle, low the next.
- Request-to-done latency: len_l+2 cycles plus hold cycles. Minimum turnaround between successive grants: len_l+3 cycles (RUN, DONE, IDLE arbitration).
- gnt always one-hot or zero; never two bits set.

## Test plan
- Reset: assert rst_n=0 mid-RUN (cnt=3) -> gnt=0, cnt=0, busy=0, done=0 immediately; after release, req=4'b0001 wins.
- Single request: req=4'b0100, len[2]=3 -> gnt=4'b0100 for 4 cycles, cnt 0,1,2,3, then done=1 with done_id=2, gnt=0.
- Round-robin: req=4'b1111 held, all len=1 -> grants in order 0,1,2,3,0; each done_id matches.
- Hold: req[1], len=5, hold=1 for 3 cycles at cnt=2 -> cnt stays 2 three cycles; done arrives 3 cycles later than nominal (cycle 10 vs 7).
- Boundaries: len=0 -> one RUN cycle cnt=0 then done; len=8'hFF -> cnt reaches 255, no wrap, done_id correct.
- Mid-run changes: drop req[0] and change len[0] during its RUN -> transaction completes with original length, done pulses once.
